// File: rtl/soc_system_pio_pkg.sv
// Shared register map, watchdog width and status bit layout
// for the motor output PIO.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_RSVD        = 3'd1;
    localparam logic [2:0] ADDR_WDOG_LOAD   = 3'd2;
    localparam logic [2:0] ADDR_WDOG_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int WDOG_W     = 24;
    localparam int STAT_TRIP  = 0;
    localparam int STAT_ARMED = 1;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_ARMED,
        WD_TRIPPED
    } wdog_state_t;

endpackage

// File: rtl/soc_system_pio_wdog.sv
// Output watchdog: a 24-bit down-counter reloaded by bus kicks;
// expiry forces the PIO outputs to their safe value until cleared.
module soc_system_pio_wdog
    import soc_system_pio_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kick,
    input  logic              load_wr,
    input  logic [WDOG_W-1:0] load_data,
    input  logic              clear,
    output logic [WDOG_W-1:0] load,
    output logic              trip,
    output logic              trip_next,
    output logic              armed
);

    localparam logic [WDOG_W-1:0] CNT_ONE = WDOG_W'(1);

    wdog_state_t       state, state_nx;
    logic [WDOG_W-1:0] cnt, cnt_nx;
    logic [WDOG_W-1:0] load_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WD_IDLE;
            cnt   <= '0;
            load  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            load  <= load_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_nx  = load;
        if (load_wr)
            load_nx = load_data;
        unique case (state)
            WD_IDLE: begin
                if (load_wr && load_data != '0) begin
                    state_nx = WD_ARMED;
                    cnt_nx   = load_data;
                end
            end
            WD_ARMED: begin
                if (load_wr) begin
                    if (load_data != '0) begin
                        cnt_nx = load_data;
                    end else begin
                        state_nx = WD_IDLE;
                        cnt_nx   = '0;
                    end
                end else if (kick) begin
                    // a kick on the expiry cycle wins over the trip
                    cnt_nx = load;
                end else if (cnt == CNT_ONE) begin
                    state_nx = WD_TRIPPED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            WD_TRIPPED: begin
                if (clear) begin
                    if (load != '0) begin
                        state_nx = WD_ARMED;
                        cnt_nx   = load;
                    end else begin
                        state_nx = WD_IDLE;
                    end
                end
            end
            default: state_nx = WD_IDLE;
        endcase
    end

    assign trip      = (state == WD_TRIPPED);
    assign armed     = (state == WD_ARMED);
    assign trip_next = (state_nx == WD_TRIPPED);

endmodule

// File: rtl/soc_system_motor_out_pio.sv
// Avalon-MM motor/LED output PIO with set/clear aliases; the optional
// output watchdog is built only when MOTOR_PIO_WDOG_EN is defined.
module soc_system_motor_out_pio
    import soc_system_pio_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter logic [DATA_W-1:0] SAFE_VALUE  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              wdog_trip
);

    logic              wr;
    logic              wr_data, wr_set, wr_clr;
    logic              tripped, trip_nx;
    logic [DATA_W-1:0] data_reg, data_nx;
    logic [31:0]       rd_nx;
    logic              unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign wr_set    = wr && (address == ADDR_OUTSET);
    assign wr_clr    = wr && (address == ADDR_OUTCLEAR);
    assign unused_wd = ^writedata;

`ifdef MOTOR_PIO_WDOG_EN
    logic              armed;
    logic [WDOG_W-1:0] load;

    soc_system_pio_wdog u_wdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .kick      (wr_data | wr_set | wr_clr),
        .load_wr   (wr && (address == ADDR_WDOG_LOAD)),
        .load_data (writedata[WDOG_W-1:0]),
        .clear     (wr && (address == ADDR_WDOG_STATUS) && writedata[0]),
        .load      (load),
        .trip      (tripped),
        .trip_next (trip_nx),
        .armed     (armed)
    );
`else
    assign tripped = 1'b0;
    assign trip_nx = 1'b0;
`endif

    // data_reg is frozen while the watchdog holds the outputs safe
    always_comb begin
        data_nx = data_reg;
        if (!tripped) begin
            if (wr_data)
                data_nx = writedata[DATA_W-1:0];
            else if (wr_set)
                data_nx = data_reg | writedata[DATA_W-1:0];
            else if (wr_clr)
                data_nx = data_reg & ~writedata[DATA_W-1:0];
        end
    end

    always_comb begin
        rd_nx = '0;
        case (address)
            ADDR_DATA: rd_nx[DATA_W-1:0] = data_reg;
`ifdef MOTOR_PIO_WDOG_EN
            ADDR_WDOG_LOAD: rd_nx[WDOG_W-1:0] = load;
            ADDR_WDOG_STATUS: begin
                rd_nx[STAT_TRIP]  = tripped;
                rd_nx[STAT_ARMED] = armed;
            end
`endif
            default: rd_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data_reg <= data_nx;
            out_port <= trip_nx ? SAFE_VALUE : data_nx;
            readdata <= rd_nx;
        end
    end

    assign wdog_trip = tripped;

endmodule

// File: tb/tb_soc_system_motor_out_pio.sv
// Scoreboard bench for soc_system_motor_out_pio; watchdog scenarios
// run when MOTOR_PIO_WDOG_EN is defined.
module tb_soc_system_motor_out_pio;

    localparam logic [7:0] SAFE = 8'hC3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        wdog_trip;

    soc_system_motor_out_pio #(
        .DATA_W      (8),
        .RESET_VALUE (8'h00),
        .SAFE_VALUE  (SAFE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .wdog_trip  (wdog_trip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endfunction

    // keep the queue sorted by due cycle
    function automatic void expect_at(int due, int sel, string name,
                                      logic [31:0] val);
        exp_t e;
        int   i;
        e = '{due: due, sel: sel, name: name, val: val};
        i = 0;
        while (i < sb.size() && sb[i].due <= due) i++;
        sb.insert(i, e);
    endfunction

    function automatic logic [31:0] sample(int sel);
        if (sel == 0) return {24'h0, out_port};
        if (sel == 1) return readdata;
        return {31'h0, wdog_trip};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc)
                    check({e.name, "_late"}, 32'(cyc), 32'(e.due));
                else
                    check(e.name, sample(e.sel), e.val);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        int e;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_at(cyc, 0, "rst_out", 32'h00);
        expect_at(cyc, 1, "rst_readdata", 32'h0);
        expect_at(cyc, 2, "rst_trip", 32'h0);

        rd(3'd0);            expect_at(cyc, 1, "rd_data_rst", 32'h00);
        wr(3'd0, 32'hA5);    expect_at(cyc, 0, "out_data_a5", 32'hA5);
        rd(3'd0);            expect_at(cyc, 1, "rd_data_a5", 32'hA5);
        wr(3'd4, 32'h0F);    expect_at(cyc, 0, "out_set_0f", 32'hAF);
        wr(3'd5, 32'h81);    expect_at(cyc, 0, "out_clr_81", 32'h2E);
        rd(3'd0);            expect_at(cyc, 1, "rd_data_2e", 32'h2E);
        rd(3'd1);            expect_at(cyc, 1, "rd_rsvd1", 32'h0);
        rd(3'd4);            expect_at(cyc, 1, "rd_outset", 32'h0);
        rd(3'd5);            expect_at(cyc, 1, "rd_outclr", 32'h0);
        wr(3'd6, 32'hFF);    expect_at(cyc, 0, "out_wr6_ign", 32'h2E);
        rd(3'd7);            expect_at(cyc, 1, "rd_rsvd7", 32'h0);
        wr(3'd0, 32'hFFFF_FF5A);
        expect_at(cyc, 0, "out_wide_wr", 32'h5A);
        rd(3'd0);            expect_at(cyc, 1, "rd_upper_zero", 32'h5A);

`ifndef MOTOR_PIO_WDOG_EN
        wr(3'd2, 32'h5);     expect_at(cyc, 0, "out_load_ign", 32'h5A);
        rd(3'd2);            expect_at(cyc, 1, "rd_load_nowd", 32'h0);
        wr(3'd3, 32'h1);
        rd(3'd3);            expect_at(cyc, 1, "rd_stat_nowd", 32'h0);
        e = cyc;
        expect_at(e + 12, 2, "trip_nowd", 32'h0);
        expect_at(e + 12, 0, "out_nowd", 32'h5A);
        while (cyc < e + 12) @(negedge clk);
`else
        wr(3'd0, 32'h3C);    expect_at(cyc, 0, "out_3c", 32'h3C);
        wr(3'd2, 32'd10);
        e = cyc;
        expect_at(e + 9, 2, "pre_trip", 32'h0);
        expect_at(e + 9, 0, "pre_trip_out", 32'h3C);
        expect_at(e + 10, 2, "trip_at_10", 32'h1);
        expect_at(e + 10, 0, "trip_out_safe", {24'h0, SAFE});
        rd(3'd2);            expect_at(cyc, 1, "rd_load_10", 32'd10);
        while (cyc < e + 10) @(negedge clk);
        rd(3'd3);            expect_at(cyc, 1, "rd_stat_trip", 32'h1);

        wr(3'd0, 32'hFF);    expect_at(cyc, 0, "out_frozen", {24'h0, SAFE});
        rd(3'd0);            expect_at(cyc, 1, "rd_data_frozen", 32'h3C);
        wr(3'd3, 32'h1);
        expect_at(cyc, 0, "out_after_clr", 32'h3C);
        expect_at(cyc, 2, "trip_after_clr", 32'h0);
        rd(3'd3);            expect_at(cyc, 1, "rd_stat_armed", 32'h2);

        wr(3'd2, 32'd10);
        e = cyc;
        while (cyc < e + 9) @(negedge clk);
        wr(3'd0, 32'h3C);
        expect_at(cyc, 2, "kick_no_trip", 32'h0);
        expect_at(cyc + 1, 2, "kick_no_trip2", 32'h0);
        expect_at(e + 19, 2, "reload_pre", 32'h0);
        expect_at(e + 20, 2, "reload_trip", 32'h1);
        while (cyc < e + 20) @(negedge clk);
        wr(3'd3, 32'h1);     expect_at(cyc, 0, "out_clr2", 32'h3C);
`endif

        wr(3'd0, 32'h55);    expect_at(cyc, 0, "out_55", 32'h55);
`ifdef MOTOR_PIO_WDOG_EN
        wr(3'd2, 32'd20);
`endif
        rd(3'd0);            expect_at(cyc, 1, "rd_55", 32'h55);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'h0, out_port}, 32'h00);
        check("async_rst_rd", readdata, 32'h0);
        check("async_rst_trip", {31'h0, wdog_trip}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        e = cyc;
        expect_at(e + 25, 2, "post_rst_trip", 32'h0);
        expect_at(e + 25, 0, "post_rst_out", 32'h00);
`ifdef MOTOR_PIO_WDOG_EN
        rd(3'd2);            expect_at(cyc, 1, "post_rst_load", 32'h0);
`endif
        while (cyc < e + 26) @(negedge clk);

        repeat (3) @(negedge clk);
        if (sb.size() != 0)
            check("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
